fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Byte-serial UART transmitter that drains the 8-bit synchronous FIFO from its read side. Whenever the FIFO is non-empty and the transmitter is idle, the block pops one byte and shifts it out as an 8N1 frame (1 start bit, 8 data bits LSB-first, 1 stop bit, no parity) on a single TX line. It sits between the FIFO read port and the board UART pin and is the outbound counterpart of the FIFO write path.

## Interface

- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- fifo_empty  input  1  FIFO empty flag
- fifo_data  input  8  FIFO registered read data; valid from the cycle after a fifo_rd_en pulse
- fifo_rd_en  output  1  one-cycle pop request to FIFO, registered
- tx  output  1  serial line, idle high, registered
- busy  output  1  high whenever state ≠ IDLE

## Operation

- States: IDLE, FETCH, WAIT, START, DATA, STOP.
- IDLE: tx=1. If fifo_empty=0 → FETCH; otherwise stay.
- FETCH (1 cycle): fifo_rd_en=1. Always → WAIT. fifo_rd_en is high only in FETCH, so exactly one pop per frame.
- WAIT (1 cycle): fifo_data is valid; it is latched into an 8-bit shift register at the end of this cycle. Baud counter cleared. → START.
- START: tx=0 for CLKS_PER_BIT cycles → DATA, bit index = 0.
- DATA: tx = shift_reg[0]; after CLKS_PER_BIT cycles shift right by one and increment the 3-bit bit index; after bit 7 completes → STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles → IDLE.
- Baud counter width is clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Bit index wraps 7→0 on the transition to STOP.
- fifo_empty is sampled only in IDLE; changes during any other state are ignored.
- A pop is never issued while fifo_empty=1.
- Reset (reset=0), asynchronous and at any time including mid-frame: state=IDLE, tx=1, fifo_rd_en=0, busy=0, counters and shift register cleared. A byte already popped and not fully sent is discarded; no retransmission.

## Timing

- Reset values: tx=1, fifo_rd_en=0, busy=0.
- Latency: fifo_empty falls in cycle N (sampled in IDLE) → fifo_rd_en=1 in cycle N+1 → WAIT in N+2 → tx falls in cycle N+3.
- Frame length: exactly 10×CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back bytes: the IDLE, FETCH, and WAIT states add 3 extra high cycles after the stop bit, so the start-to-start period is 10×CLKS_PER_BIT+3 cycles.
- busy rises with FETCH and falls on the cycle IDLE is re-entered.
- All outputs are glitch-free registered values; tx changes only on bit boundaries.

## Test plan

- Reset hold: reset=0 with fifo_empty=0 and arbitrary fifo_data → tx=1, fifo_rd_en=0, busy=0 throughout; after release, the first fifo_rd_en appears 1 cycle after the first clk edge that samples reset=1.
- Single byte, CLKS_PER_BIT=4: FIFO holds 0xA5 → one fifo_rd_en pulse; tx = 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop); each bit 4 cycles; busy falls 40 cycles after tx falls.
- Back-to-back, CLKS_PER_BIT=4: FIFO holds 0x00 then 0xFF → two fifo_rd_en pulses 43 cycles apart; 0x00 frame is low for 36 cycles; after the stop bit the line stays high for 4+3 cycles before the next start bit; 0xFF frame has only its start bit low.
- Empty FIFO: fifo_empty=1 for 100 cycles → fifo_rd_en never asserts, tx=1, busy=0.
- Flag ignored mid-frame: fifo_empty toggles during DATA → no extra pops; the frame is unchanged.
- Reset mid-frame: assert reset=0 during bit 3 of 0x3C → tx=1 immediately (asynchronous), busy=0; after release with FIFO empty, no frame is sent and no fifo_rd_en is issued.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that drains a synchronous FIFO read port.
// One pop per frame; the popped byte is shifted out LSB-first on tx.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!fifo_empty) begin
          state_d = S_FETCH;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      // Read data is valid now: capture it and drive the start bit.
      S_WAIT: begin
        cnt_d   = '0;
        idx_d   = '0;
        sh_d    = fifo_data;
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          sh_d  = sh_q >> 1;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = sh_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  assign fifo_rd_en = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeds bytes, a UART receiver
// model rebuilds each frame and checks it against a queue of pushes.
module tb_fifo_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fake_ne = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         pop_cyc[$];
  int         start_cyc[$];
  int         n_push = 0;
  int         pops = 0;
  int         cyc = 0;
  int         frames = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         in_frame = 1'b0;

  assign fifo_empty = (n_push == pops) && !fake_ne;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    n_push++;
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy && !in_frame && exp_q.size() == 0 && n_push == pops) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_frame) break;
    end
    check("frame_seen", 32'(in_frame), 32'd1);
  endtask

  // FIFO read side: registered data, one entry per rd_en cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      check("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      pop_cyc.push_back(cyc);
      if (fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
      pops <= pops + 1;
    end
  end

  // Receiver: every cycle of each 10-bit frame must match {1,byte,0}.
  initial begin
    logic [7:0] e;
    logic [9:0] f;
    bit         ok;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        in_frame = 1'b1;
        start_cyc.push_back(cyc);
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        f = {1'b1, e, 1'b0};
        aborted = 1'b0;
        for (int b = 0; b < 10; b++) begin
          ok = 1'b1;
          for (int i = 0; i < C; i++) begin
            if (b != 0 || i != 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (tx !== f[b]) ok = 1'b0;
          end
          if (aborted) break;
          check($sformatf("byte%02h_bit%0d_ok", e, b), 32'(ok), 32'd1);
        end
        if (!aborted) begin
          @(negedge clk);
          check("busy_low_after_stop", 32'(busy), 32'd0);
          check("tx_high_after_stop", 32'(tx), 32'd1);
          frames++;
        end
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    bit ok_t, ok_r, ok_b, ok;
    int p0, pc, sc, f0;

    // Reset hold with a non-empty FIFO
    repeat (2) @(negedge clk);
    push(8'h5A);
    fifo_data = 8'($urandom);
    ok_t = 1; ok_r = 1; ok_b = 1;
    repeat (10) begin
      @(negedge clk);
      if (tx !== 1'b1) ok_t = 0;
      if (fifo_rd_en !== 1'b0) ok_r = 0;
      if (busy !== 1'b0) ok_b = 0;
    end
    check("rst_tx_high", 32'(ok_t), 32'd1);
    check("rst_rd_low", 32'(ok_r), 32'd1);
    check("rst_busy_low", 32'(ok_b), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rd_after_release", 32'(fifo_rd_en), 32'd1);
    wait_idle(200);

    // Single byte 0xA5: latency and one pop
    p0 = pops;
    push(8'hA5);
    @(negedge clk);
    check("lat_fetch", 32'({fifo_rd_en, busy}), 32'b11);
    @(negedge clk);
    check("lat_wait", 32'({fifo_rd_en, tx}), 32'b01);
    @(negedge clk);
    check("lat_start_tx", 32'(tx), 32'd0);
    wait_idle(200);
    check("single_pops", 32'(pops - p0), 32'd1);

    // Back-to-back 0x00 then 0xFF
    p0 = pops;
    pc = pop_cyc.size();
    sc = start_cyc.size();
    push(8'h00);
    push(8'hFF);
    wait_idle(300);
    check("b2b_pops", 32'(pops - p0), 32'd2);
    if (pop_cyc.size() >= pc + 2)
      check("b2b_pop_gap", 32'(pop_cyc[pc+1] - pop_cyc[pc]), 32'd43);
    else
      check("b2b_pop_count", 32'(pop_cyc.size() - pc), 32'd2);
    if (start_cyc.size() >= sc + 2)
      check("b2b_start_gap", 32'(start_cyc[sc+1] - start_cyc[sc]), 32'd43);
    else
      check("b2b_start_count", 32'(start_cyc.size() - sc), 32'd2);

    // Empty FIFO for 100 cycles
    ok_t = 1; ok_r = 1; ok_b = 1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) ok_t = 0;
      if (fifo_rd_en !== 1'b0) ok_r = 0;
      if (busy !== 1'b0) ok_b = 0;
    end
    check("empty_tx_high", 32'(ok_t), 32'd1);
    check("empty_no_rd", 32'(ok_r), 32'd1);
    check("empty_not_busy", 32'(ok_b), 32'd1);

    // fifo_empty toggling mid-frame is ignored
    p0 = pops;
    push(8'h96);
    wait_frame();
    repeat (8) @(negedge clk);
    repeat (20) begin
      fake_ne = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    fake_ne = 1'b0;
    wait_idle(200);
    check("toggle_pops", 32'(pops - p0), 32'd1);

    // Reset during bit 3 of 0x3C
    push(8'h3C);
    wait_frame();
    repeat (17) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    p0 = pops;
    f0 = frames;
    ok = 1;
    repeat (60) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) ok = 0;
    end
    check("midrst_quiet", 32'(ok), 32'd1);
    check("midrst_no_pop", 32'(pops - p0), 32'd0);
    check("midrst_no_frame", 32'(frames - f0), 32'd0);

    // Random bytes with random gaps
    p0 = pops;
    f0 = frames;
    for (int k = 0; k < 40; k++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_idle(5000);
    check("rand_pops", 32'(pops - p0), 32'd40);
    check("rand_frames", 32'(frames - f0), 32'd40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
